// File: rtl/ble_uart_pkg.sv
// Shared types and helpers for the Bluetooth-link UART receiver.
package ble_uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // sys_clk cycles per oversampling tick, truncated
  function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
    return clk_freq / (baud * oversample);
  endfunction

endpackage

// File: rtl/ble_uart_rx_baud_tick_gen.sv
// Oversampling tick enable: one sys_clk pulse every DIV cycles, restartable.
module baud_tick_gen
  import ble_uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst)                 cnt <= '0;
    else if (restart || tick) cnt <= '0;
    else                     cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/ble_uart_rx.sv
// UART receiver: synchronised input, validated start bit, mid-bit sampling,
// optional parity, frame/parity error flags qualified by rx_valid.
module ble_uart_rx
  import ble_uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 ble_rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_busy
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  state_t               state, state_n;
  logic [1:0]           sync;
  logic                 rxd_s;
  logic                 tick, restart;
  logic [SW-1:0]        scnt;
  logic [BW-1:0]        bcnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err;
  logic                 mid_start, mid_bit, last_bit;

  assign rxd_s     = sync[1];
  assign mid_start = tick && (scnt == SW'(OVERSAMPLE/2 - 1));
  assign mid_bit   = tick && (scnt == SW'(OVERSAMPLE - 1));
  assign last_bit  = (bcnt == BW'(DATA_BITS - 1));
  assign rx_busy   = (state != S_IDLE);

  baud_tick_gen #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .sys_clk(sys_clk),
    .rst    (rst),
    .restart(restart),
    .tick   (tick)
  );

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // STOP returns to IDLE at mid-bit so a back-to-back start edge is not missed
  always_comb begin
    state_n = state;
    restart = 1'b0;
    case (state)
      S_IDLE:   if (!rxd_s) begin state_n = S_START; restart = 1'b1; end
      S_START:  if (mid_start) state_n = rxd_s ? S_IDLE : S_DATA;
      S_DATA:   if (mid_bit && last_bit) state_n = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
      S_PARITY: if (mid_bit) state_n = S_STOP;
      S_STOP:   if (mid_bit) state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      sync          <= 2'b11;
      scnt          <= '0;
      bcnt          <= '0;
      shreg         <= '0;
      par_err       <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      sync     <= {sync[0], ble_rxd};
      rx_valid <= 1'b0;
      if (state == S_IDLE) begin
        scnt    <= '0;
        bcnt    <= '0;
        par_err <= 1'b0;
      end else if (tick) begin
        scnt <= (mid_bit || (state == S_START && mid_start)) ? '0 : scnt + 1'b1;
        case (state)
          S_DATA: if (mid_bit) begin
            shreg <= {rxd_s, shreg[DATA_BITS-1:1]};
            bcnt  <= last_bit ? '0 : bcnt + 1'b1;
          end
          S_PARITY: if (mid_bit)
            par_err <= ((^shreg) ^ rxd_s) != (PARITY == PAR_ODD);
          S_STOP: if (mid_bit) begin
            rx_data       <= shreg;
            rx_frame_err  <= !rxd_s;
            rx_parity_err <= par_err;
            rx_valid      <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ble_uart_rx.sv
// Directed bench: three receivers (8N1, 8E1, 7N1) sharing clock and reset.
module tb_ble_uart_rx;

  localparam int BIT = 432;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] rxd = 3'b111;

  always #5 clk = ~clk;

  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic v0, v1, v2, pe0, pe1, pe2, fe0, fe1, fe2, b0, b1, b2;

  ble_uart_rx dut0 (.sys_clk(clk), .rst(rst), .ble_rxd(rxd[0]), .rx_data(d0), .rx_valid(v0),
                    .rx_parity_err(pe0), .rx_frame_err(fe0), .rx_busy(b0));
  ble_uart_rx #(.PARITY(1)) dut1 (.sys_clk(clk), .rst(rst), .ble_rxd(rxd[1]), .rx_data(d1),
                    .rx_valid(v1), .rx_parity_err(pe1), .rx_frame_err(fe1), .rx_busy(b1));
  ble_uart_rx #(.DATA_BITS(7)) dut2 (.sys_clk(clk), .rst(rst), .ble_rxd(rxd[2]), .rx_data(d2),
                    .rx_valid(v2), .rx_parity_err(pe2), .rx_frame_err(fe2), .rx_busy(b2));

  int checks = 0;
  int errors = 0;
  longint cyc = 0;
  longint t_valid0 = 0;
  logic [10:0] q0[$], q1[$], q2[$];

  always @(posedge clk) cyc <= cyc + 1;

  // one queue entry per cycle of rx_valid, so a stretched pulse shows as an extra frame
  always @(negedge clk) begin
    if (v0) begin q0.push_back({pe0, fe0, 1'b0, d0}); t_valid0 = cyc; end
    if (v1) q1.push_back({pe1, fe1, 1'b0, d1});
    if (v2) q2.push_back({pe2, fe2, 2'b00, d2});
  end

  typedef struct {
    int         sel;
    logic [8:0] data;
    logic       pb;
    logic       sb;
    logic [8:0] exp_d;
    logic       exp_f;
    logic       exp_p;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input int sel, input logic b);
    rxd[sel] = b;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_frame(input int sel, input logic [8:0] data, input int nb,
                            input bit pen, input logic pb, input logic sb);
    drive_bit(sel, 1'b0);
    for (int i = 0; i < nb; i++) drive_bit(sel, data[i]);
    if (pen) drive_bit(sel, pb);
    drive_bit(sel, sb);
    rxd[sel] = 1'b1;
  endtask

  task automatic wait_pop(input int sel, output logic [10:0] v, output bit ok);
    int n = 0;
    int sz;
    v  = '0;
    ok = 1'b0;
    sz = (sel == 0) ? q0.size() : (sel == 1) ? q1.size() : q2.size();
    while (sz == 0 && n < 2000) begin
      @(negedge clk);
      n++;
      sz = (sel == 0) ? q0.size() : (sel == 1) ? q1.size() : q2.size();
    end
    if (sz == 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: no rx_valid on receiver %0d", sel);
    end else begin
      ok = 1'b1;
      case (sel)
        0: v = q0.pop_front();
        1: v = q1.pop_front();
        default: v = q2.pop_front();
      endcase
    end
  endtask

  task automatic expect_frame(input string name, input int sel, input logic [8:0] ed,
                              input logic ef, input logic ep);
    logic [10:0] v;
    bit ok;
    wait_pop(sel, v, ok);
    if (ok) begin
      check({name, " data"}, 32'(v[8:0]), 32'(ed));
      check({name, " frame_err"}, 32'(v[9]), 32'(ef));
      check({name, " parity_err"}, 32'(v[10]), 32'(ep));
    end
  endtask

  initial begin
    longint t0;
    longint lat;
    int nb;

    vecs[0] = '{0, 9'h03C, 1'b0, 1'b0, 9'h03C, 1'b1, 1'b0};
    vecs[1] = '{1, 9'h007, 1'b1, 1'b1, 9'h007, 1'b0, 1'b0};
    vecs[2] = '{1, 9'h007, 1'b0, 1'b1, 9'h007, 1'b0, 1'b1};
    vecs[3] = '{1, 9'h05A, 1'b1, 1'b1, 9'h05A, 1'b0, 1'b1};
    vecs[4] = '{1, 9'h05A, 1'b0, 1'b1, 9'h05A, 1'b0, 1'b0};
    vecs[5] = '{1, 9'h080, 1'b1, 1'b0, 9'h080, 1'b1, 1'b0};
    vecs[6] = '{2, 9'h07F, 1'b0, 1'b1, 9'h07F, 1'b0, 1'b0};
    vecs[7] = '{2, 9'h02A, 1'b0, 1'b0, 9'h02A, 1'b1, 1'b0};
    vecs[8] = '{0, 9'h0C3, 1'b0, 1'b1, 9'h0C3, 1'b0, 1'b0};

    repeat (5) @(negedge clk);
    check("reset rx_data", 32'(d0), 32'h0);
    check("reset rx_valid", 32'(v0), 32'h0);
    check("reset parity_err", 32'(pe0), 32'h0);
    check("reset frame_err", 32'(fe0), 32'h0);
    check("reset busy", 32'({b0, b1, b2}), 32'h0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // first frame also measures edge-to-valid latency (2 + 9.5 bits, +-1 tick)
    t0 = cyc;
    send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1'b1);
    expect_frame("8N1 A5", 0, 9'h0A5, 1'b0, 1'b0);
    lat = t_valid0 - t0;
    check("latency in window", 32'(lat >= 4106 - 30 && lat <= 4106 + 30), 32'h1);
    repeat (2*BIT) @(negedge clk);

    // 100-cycle low glitch: start bit rejected at its mid-point
    rxd[0] = 1'b0;
    repeat (20) @(negedge clk);
    check("glitch busy high", 32'(b0), 32'h1);
    repeat (80) @(negedge clk);
    rxd[0] = 1'b1;
    repeat (250) @(negedge clk);
    check("glitch busy cleared", 32'(b0), 32'h0);
    check("glitch no valid", 32'(q0.size()), 32'h0);

    for (int i = 0; i < 9; i++) begin
      nb = (vecs[i].sel == 2) ? 7 : 8;
      send_frame(vecs[i].sel, vecs[i].data, nb, vecs[i].sel == 1, vecs[i].pb, vecs[i].sb);
      expect_frame($sformatf("vec%0d", i), vecs[i].sel, vecs[i].exp_d, vecs[i].exp_f, vecs[i].exp_p);
      repeat (2*BIT) @(negedge clk);
    end

    // back-to-back frames, no idle gap
    send_frame(0, 9'h000, 8, 1'b0, 1'b0, 1'b1);
    send_frame(0, 9'h0FF, 8, 1'b0, 1'b0, 1'b1);
    send_frame(0, 9'h055, 8, 1'b0, 1'b0, 1'b1);
    expect_frame("b2b 00", 0, 9'h000, 1'b0, 1'b0);
    expect_frame("b2b FF", 0, 9'h0FF, 1'b0, 1'b0);
    expect_frame("b2b 55", 0, 9'h055, 1'b0, 1'b0);
    repeat (2*BIT) @(negedge clk);

    // reset in bit 4 of 0x81, held until the line is idle again
    fork
      send_frame(0, 9'h081, 8, 1'b0, 1'b0, 1'b1);
      begin
        repeat (4*BIT + BIT/2) @(negedge clk);
        rst = 1'b1;
      end
    join
    repeat (BIT) @(negedge clk);
    check("mid reset rx_data", 32'(d0), 32'h0);
    check("mid reset busy", 32'(b0), 32'h0);
    check("mid reset no valid", 32'(q0.size()), 32'h0);
    rst = 1'b0;
    repeat (BIT) @(negedge clk);
    send_frame(0, 9'h042, 8, 1'b0, 1'b0, 1'b1);
    expect_frame("after reset 42", 0, 9'h042, 1'b0, 1'b0);
    repeat (2*BIT) @(negedge clk);

    check("no stray frames dut0", 32'(q0.size()), 32'h0);
    check("no stray frames dut1", 32'(q1.size()), 32'h0);
    check("no stray frames dut2", 32'(q2.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
